// File: rtl/rr_arb_pkg.sv
// ============================================================================
// Module : rr_arb_pkg
// Brief  : Shared sizing helpers and arbiter FSM encodings for rr_router_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rr_arb_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Destination / pointer width; never narrower than one bit.
    function automatic int dest_w(input int num_ch);
        return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
    endfunction

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational rotate-priority picker: first requester after ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = dest_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_grant,
    output logic [IDX_W-1:0]  o_grant_idx,
    output logic              o_grant_valid
);

    int w_idx;

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_idx         = 0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_idx = (int'(i_ptr) + k) % NUM_CH;
            if (i_req[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = IDX_W'(w_idx);
                o_grant_valid  = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_router_arbiter.sv
// ============================================================================
// Module : rr_router_arbiter
// Brief  : Round-robin pop from NUM_CH input FIFOs, routed by destination field
//          to NUM_CH output FIFOs. Optional grant counters: RR_ARB_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_router_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 10,
    parameter int DEST_LSB = 8
`ifdef RR_ARB_STATS_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_empty,
    output logic [NUM_CH-1:0]        in_pop,
    input  logic [NUM_CH-1:0]        out_almost_full,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_push,
    output logic                     drop_err,
    output logic                     idle
`ifdef RR_ARB_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0]  grant_cnt
`endif
);

    localparam int                 c_IDX_W   = dest_w(NUM_CH);
    localparam logic [c_IDX_W-1:0] c_PTR_RST = c_IDX_W'(NUM_CH - 1);

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic                w_stall;
    logic                w_arb_en;
    logic                w_pop_en;
    logic [NUM_CH-1:0]   w_grant;
    logic [c_IDX_W-1:0]  w_grant_idx;
    logic                w_grant_valid;
    logic [c_IDX_W-1:0]  r_ptr;
    logic                r_s0_valid;
    logic [c_IDX_W-1:0]  r_s0_ch;
    logic                r_s1_valid;
    logic [DATA_W-1:0]   w_in_word [NUM_CH];
    logic [DATA_W-1:0]   w_word;
    logic [c_IDX_W-1:0]  w_dest;
    logic                w_dest_ok;
    logic [NUM_CH-1:0]   w_push_nxt;
    logic [DATA_W-1:0]   r_out_data [NUM_CH];
    logic [NUM_CH-1:0]   r_out_push;
    logic                r_drop;

    assign w_stall = |out_almost_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= RUN;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_arb_en    = 1'b0;
        case (r_state)
            RUN: begin
                if (w_stall) w_state_nxt = HOLD;
                else         w_arb_en    = 1'b1;
            end
            HOLD: begin
                if (!w_stall) begin
                    w_state_nxt = RUN;
                    w_arb_en    = 1'b1;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (c_IDX_W)
    ) u_pick (
        .i_req         (~in_empty),
        .i_ptr         (r_ptr),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    // Gating with the raw reset input keeps pops low during the reset pulse itself.
    assign w_pop_en = w_arb_en & reset & w_grant_valid;
    assign in_pop   = w_pop_en ? w_grant : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr      <= c_PTR_RST;
            r_s0_valid <= 1'b0;
            r_s0_ch    <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            if (w_pop_en) r_ptr <= w_grant_idx;
            r_s0_valid <= w_pop_en;
            r_s0_ch    <= w_grant_idx;
            r_s1_valid <= r_s0_valid;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        assign w_in_word[i]                    = in_data[i*DATA_W +: DATA_W];
        assign out_data[i*DATA_W +: DATA_W]    = r_out_data[i];
    end

    // The FIFO presents the popped word one cycle after the pop strobe.
    assign w_word = w_in_word[r_s0_ch];
    assign w_dest = w_word[DEST_LSB +: c_IDX_W];

    if ((1 << c_IDX_W) == NUM_CH) begin : g_dest_pow2
        assign w_dest_ok = 1'b1;
    end else begin : g_dest_chk
        assign w_dest_ok = (int'(w_dest) < NUM_CH);
    end

    assign w_push_nxt = (r_s0_valid && w_dest_ok) ? (NUM_CH'(1) << w_dest) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_push <= '0;
            r_drop     <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) r_out_data[i] <= '0;
        end else begin
            r_out_push <= w_push_nxt;
            r_drop     <= r_s0_valid & ~w_dest_ok;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_push_nxt[i]) r_out_data[i] <= w_word;
            end
        end
    end

    assign out_push = r_out_push;
    assign drop_err = r_drop;
    assign idle     = ~|in_pop & ~r_s0_valid & ~r_s1_valid;

`ifdef RR_ARB_STATS_EN
    logic [CNT_W-1:0] r_cnt [NUM_CH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (in_pop[i] && (r_cnt[i] != {CNT_W{1'b1}})) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
        assign grant_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_router_arbiter.sv
// ============================================================================
// Module : tb_rr_router_arbiter
// Brief  : Randomised bench with a queue-level reference model of the router.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_router_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [39:0] in_data = '0;
    logic [3:0]  in_empty = '1;
    logic [3:0]  in_pop;
    logic [3:0]  out_almost_full = '0;
    logic [39:0] out_data;
    logic [3:0]  out_push;
    logic        drop_err;
    logic        idle;

    logic        reset3 = 1'b1;
    logic [29:0] in_data3 = '0;
    logic [2:0]  in_empty3 = '1;
    logic [2:0]  in_pop3;
    logic [2:0]  af3 = '0;
    logic [29:0] out_data3;
    logic [2:0]  out_push3;
    logic        drop3;
    logic        idle3;
`ifdef RR_ARB_STATS_EN
    logic [15:0] grant_cnt;
    logic [11:0] grant_cnt3;
`endif

    always #5 clk = ~clk;

    rr_router_arbiter #(
        .NUM_CH(4), .DATA_W(10), .DEST_LSB(8)
`ifdef RR_ARB_STATS_EN
        , .CNT_W(4)
`endif
    ) u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_empty(in_empty), .in_pop(in_pop),
        .out_almost_full(out_almost_full), .out_data(out_data), .out_push(out_push),
        .drop_err(drop_err), .idle(idle)
`ifdef RR_ARB_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    rr_router_arbiter #(
        .NUM_CH(3), .DATA_W(10), .DEST_LSB(8)
`ifdef RR_ARB_STATS_EN
        , .CNT_W(4)
`endif
    ) u_dut3 (
        .clk(clk), .reset(reset3), .in_data(in_data3), .in_empty(in_empty3), .in_pop(in_pop3),
        .out_almost_full(af3), .out_data(out_data3), .out_push(out_push3),
        .drop_err(drop3), .idle(idle3)
`ifdef RR_ARB_STATS_EN
        , .grant_cnt(grant_cnt3)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: last granted channel, the channel popped last cycle,
    // and what the output side must show this cycle.
    int         m_ptr;
    bit         m_s0_v;
    int         m_s0_ch;
    logic [3:0] m_push;
    bit         m_drop;
    logic [9:0] m_data [4];
    int         m_cnt  [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 3;
        m_s0_v  = 0;
        m_s0_ch = 0;
        m_push  = '0;
        m_drop  = 0;
        for (int i = 0; i < 4; i++) begin
            m_data[i] = '0;
            m_cnt[i]  = 0;
        end
    endtask

    function automatic int pick(input logic [3:0] emp);
        for (int k = 1; k <= 4; k++) begin
            if (!emp[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic step(input bit rst, input logic [3:0] emp, input logic [3:0] af, input logic [39:0] dat);
        int         g;
        logic [3:0] exp_pop;
        logic [39:0] exp_data;
        logic [9:0] w;
        bit         exp_idle;
        @(negedge clk);
        reset = rst; in_empty = emp; out_almost_full = af; in_data = dat;
        #1;
        if (!rst) model_reset();
        g        = (rst && af == 4'b0) ? pick(emp) : -1;
        exp_pop  = (g >= 0) ? 4'(1 << g) : 4'b0;
        exp_data = {m_data[3], m_data[2], m_data[1], m_data[0]};
        exp_idle = (g < 0) && !m_s0_v && (m_push == 4'b0) && !m_drop;
        chk("in_pop", 64'(in_pop), 64'(exp_pop));
        chk("out_push", 64'(out_push), 64'(m_push));
        chk("drop_err", 64'(drop_err), 64'(m_drop));
        chk("out_data", 64'(out_data), 64'(exp_data));
        chk("idle", 64'(idle), 64'(exp_idle));
`ifdef RR_ARB_STATS_EN
        chk("grant_cnt", 64'(grant_cnt),
            64'({4'(m_cnt[3]), 4'(m_cnt[2]), 4'(m_cnt[1]), 4'(m_cnt[0])}));
`endif
        if (rst) begin
            m_push = '0;
            m_drop = 0;
            if (m_s0_v) begin
                w = dat[m_s0_ch*10 +: 10];
                m_push[w[9:8]] = 1'b1;
                m_data[w[9:8]] = w;
            end
            m_s0_v  = (g >= 0);
            m_s0_ch = g;
            if (g >= 0) begin
                m_ptr = g;
                if (m_cnt[g] < 15) m_cnt[g]++;
            end
        end
    endtask

    function automatic logic [39:0] rnd_data();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[39:0];
    endfunction

    initial begin
        logic [3:0]  seq [4];
        logic [39:0] d;
        logic [3:0]  af;
        model_reset();

        // Reset with every input non-empty: nothing may pop.
        repeat (3) begin
            step(0, 4'b0000, 4'b0000, rnd_data());
            chk("rst_pop", 64'(in_pop), 64'h0);
            chk("rst_push", 64'(out_push), 64'h0);
            chk("rst_idle", 64'(idle), 64'h1);
        end
        step(1, 4'b0000, 4'b0000, rnd_data());
        chk("first_pop", 64'(in_pop), 64'h1);

        seq[0] = 4'b0010; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step(1, 4'b0000, 4'b0000, rnd_data());
            chk("rr_seq", 64'(in_pop), 64'(seq[i]));
        end
        step(1, 4'b1111, 4'b0000, rnd_data());
        step(1, 4'b1111, 4'b0000, rnd_data());

        // Single word on ch2 routed to output 2.
        d = rnd_data();
        d[29:20] = 10'h2C5;
        step(1, 4'b1011, 4'b0000, d);
        chk("ch2_pop", 64'(in_pop), 64'h4);
        step(1, 4'b1111, 4'b0000, d);
        step(1, 4'b1111, 4'b0000, d);
        chk("ch2_push", 64'(out_push), 64'h4);
        chk("ch2_data", 64'(out_data[29:20]), 64'h2C5);

        // Stall in the middle of a stream.
        repeat (3) step(1, 4'b0000, 4'b0000, rnd_data());
        repeat (4) begin
            step(1, 4'b0000, 4'b0010, rnd_data());
            chk("stall_pop", 64'(in_pop), 64'h0);
        end
        repeat (3) step(1, 4'b0000, 4'b0000, rnd_data());

        for (int i = 0; i < 800; i++) begin
            af = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0;
            step(($urandom_range(99) != 0), 4'($urandom), af, rnd_data());
        end

`ifdef RR_ARB_STATS_EN
        step(0, 4'b1111, 4'b0000, rnd_data());
        chk("cnt_clr", 64'(grant_cnt), 64'h0);
        repeat (20) step(1, 4'b1110, 4'b0000, rnd_data());
        chk("cnt_sat", 64'(grant_cnt[3:0]), 64'hF);
        step(0, 4'b1110, 4'b0000, rnd_data());
        chk("cnt_rst", 64'(grant_cnt), 64'h0);
`endif

        // Three-channel instance: illegal destination 3 is dropped.
        step(0, 4'b1111, 4'b0000, rnd_data());
        @(negedge clk); reset3 = 1'b0; in_empty3 = 3'b111; #1;
        chk("n3_rst_pop", 64'(in_pop3), 64'h0);
        @(negedge clk); reset3 = 1'b1; in_empty3 = 3'b110; in_data3 = 30'h0; #1;
        chk("n3_pop0", 64'(in_pop3), 64'h1);
        @(negedge clk); in_empty3 = 3'b101; in_data3[9:0] = 10'h3AA; #1;
        chk("n3_pop1", 64'(in_pop3), 64'h2);
        @(negedge clk); in_empty3 = 3'b111; in_data3[19:10] = 10'h155; #1;
        chk("n3_drop", 64'(drop3), 64'h1);
        chk("n3_nopush", 64'(out_push3), 64'h0);
        @(negedge clk); #1;
        chk("n3_drop_end", 64'(drop3), 64'h0);
        chk("n3_push1", 64'(out_push3), 64'h2);
        chk("n3_data1", 64'(out_data3[19:10]), 64'h155);
        @(negedge clk); #1;
        chk("n3_idle", 64'(idle3), 64'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
